// File: rtl/alu_shift_pkg.sv
// Shared types for the shift/rotate arbiter: opcodes, response-register states and the opcode legality check.
// The optional illegal-opcode flag (ALU_SHIFT_ILLEGAL_FLAG_EN) is handled in alu_shift_arbiter.
package alu_shift_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [3:0] {
    OP_SLL  = 4'b0110,
    OP_SAR  = 4'b0111,
    OP_ROTL = 4'b1000,
    OP_ROTR = 4'b1001
  } shift_op_e;

  typedef enum logic {
    RESP_EMPTY = 1'b0,
    RESP_FULL  = 1'b1
  } resp_state_e;

  function automatic logic is_legal_op(shift_op_e op);
    return op inside {OP_SLL, OP_SAR, OP_ROTL, OP_ROTR};
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Purely combinational 16-bit shift/rotate datapath. Shifts saturate for amounts >= 16,
// rotates use only the low four bits of the amount, and illegal opcodes yield zero.
module alu_shift_unit
  import alu_shift_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [3:0]        opcode_i,
  output logic [DATA_W-1:0] result_o
);

  logic [3:0]        amt;
  logic              overRange;
  logic signed [DATA_W-1:0] aSigned;

  always_comb begin
    amt       = b_i[3:0];
    overRange = |b_i[DATA_W-1:4];
    aSigned   = $signed(a_i);
    result_o  = '0;
    case (opcode_i)
      OP_SLL:  result_o = overRange ? '0 : (a_i << amt);
      OP_SAR:  result_o = overRange ? {DATA_W{a_i[DATA_W-1]}} : DATA_W'(aSigned >>> amt);
      // A shift by the full width yields zero, so amount 0 returns A unchanged.
      OP_ROTL: result_o = (a_i << amt) | (a_i >> (5'd16 - {1'b0, amt}));
      OP_ROTR: result_o = (a_i >> amt) | (a_i << (5'd16 - {1'b0, amt}));
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_shift_arbiter.sv
// Round-robin arbiter sharing one shift unit between NUM_REQ requesters, with a single-entry tagged response register.
// Defining ALU_SHIFT_ILLEGAL_FLAG_EN adds resp_illegal, registered alongside the response.
module alu_shift_arbiter
  import alu_shift_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]      req_opcode,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_W-1:0]         resp_result,
  output logic [ID_W-1:0]           resp_id
`ifdef ALU_SHIFT_ILLEGAL_FLAG_EN
  , output logic                    resp_illegal
`endif
);

  resp_state_e       state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rrPtr_q, rrPtr_d;

  logic              grantValid;
  logic [ID_W-1:0]   grantIdx;
  logic [ID_W-1:0]   candIdx;
  logic              canAccept;
  logic              accept;
  logic [DATA_W-1:0] selA, selB, unitResult;
  logic [3:0]        selOp;

  // Grant depends only on valids, pointer and response state, never on operand data.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    candIdx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      candIdx = ID_W'((int'(rrPtr_q) + k) % NUM_REQ);
      if (!grantValid && req_valid[candIdx]) begin
        grantValid = 1'b1;
        grantIdx   = candIdx;
      end
    end
    canAccept = rst_n && ((state_q == RESP_EMPTY) || resp_ready);
    accept    = canAccept && grantValid;
    req_ready = '0;
    if (accept) req_ready[grantIdx] = 1'b1;
  end

  assign selA  = req_a[grantIdx*DATA_W +: DATA_W];
  assign selB  = req_b[grantIdx*DATA_W +: DATA_W];
  assign selOp = req_opcode[grantIdx*4 +: 4];

  alu_shift_unit uShiftUnit (
    .a_i      (selA),
    .b_i      (selB),
    .opcode_i (selOp),
    .result_o (unitResult)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    id_d     = id_q;
    rrPtr_d  = rrPtr_q;
    if (accept) begin
      state_d  = RESP_FULL;
      result_d = unitResult;
      id_d     = grantIdx;
      rrPtr_d  = (grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
    end else if (state_q == RESP_FULL && resp_ready) begin
      state_d = RESP_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RESP_EMPTY;
      result_q <= '0;
      id_q     <= '0;
      rrPtr_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      id_q     <= id_d;
      rrPtr_q  <= rrPtr_d;
    end
  end

  assign resp_valid  = (state_q == RESP_FULL);
  assign resp_result = result_q;
  assign resp_id     = id_q;

`ifdef ALU_SHIFT_ILLEGAL_FLAG_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (accept) begin
      illegal_q <= !is_legal_op(shift_op_e'(selOp));
    end
  end

  assign resp_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_alu_shift_arbiter.sv
// Directed self-checking bench for alu_shift_arbiter (NUM_REQ=4); resp_illegal is checked when ALU_SHIFT_ILLEGAL_FLAG_EN is defined.
module tb_alu_shift_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int ID_W    = 2;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*4-1:0]      req_opcode;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [DATA_W-1:0]         resp_result;
  logic [ID_W-1:0]           resp_id;
`ifdef ALU_SHIFT_ILLEGAL_FLAG_EN
  logic                      resp_illegal;
`endif

  int compared   = 0;
  int mismatched = 0;

  alu_shift_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_opcode  (req_opcode),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_id     (resp_id)
`ifdef ALU_SHIFT_ILLEGAL_FLAG_EN
    , .resp_illegal (resp_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int idx, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    req_a[idx*DATA_W +: DATA_W] = a;
    req_b[idx*DATA_W +: DATA_W] = b;
    req_opcode[idx*4 +: 4]      = op;
    req_valid[idx]              = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    resp_ready = 1'b1;
    req_valid  = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (resp_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", resp_valid);
    end
    compared++;
    if (resp_result !== 16'h0000 || resp_id !== 2'd0) begin
      mismatched++; $display("[TB] FAIL reset_regs: got result=%h id=%0d expected 0000/0", resp_result, resp_id);
    end
    compared++;
    if (req_ready !== 4'b0000) begin
      mismatched++; $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready);
    end
  endtask

  task automatic test_single();
    rst_n     = 1'b1;
    req_valid = '0;
    set_req(0, 4'b0110, 16'h0001, 16'd4);
    #1;
    compared++;
    if (req_ready !== 4'b0001) begin
      mismatched++; $display("[TB] FAIL single_ready: got %b expected 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    compared++;
    if (resp_valid !== 1'b1 || resp_result !== 16'h0010 || resp_id !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL single_resp: got v=%b r=%h id=%0d expected 1/0010/0", resp_valid, resp_result, resp_id);
    end
    @(posedge clk); #1;
    compared++;
    if (resp_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL single_drain: got %b expected 0", resp_valid);
    end
  endtask

  task automatic test_arith();
    logic [3:0]  ops  [10];
    logic [15:0] as   [10];
    logic [15:0] bs   [10];
    logic [15:0] exps [10];
    ops  = '{4'b0111, 4'b0111, 4'b1000, 4'b1001, 4'b0110, 4'b0110, 4'b1000, 4'b1001, 4'b0111, 4'b1111};
    as   = '{16'h8000, 16'h8000, 16'h8001, 16'h8001, 16'h0001, 16'h00FF, 16'h1234, 16'h1234, 16'h7000, 16'hFFFF};
    bs   = '{16'd3, 16'd20, 16'd1, 16'd17, 16'd16, 16'd15, 16'd16, 16'd4, 16'd20, 16'd1};
    exps = '{16'hF000, 16'hFFFF, 16'h0003, 16'hC000, 16'h0000, 16'h8000, 16'h1234, 16'h4123, 16'h0000, 16'h0000};
    for (int i = 0; i < 10; i++) begin
      req_valid = '0;
      set_req(i % 4, ops[i], as[i], bs[i]);
      #1;
      compared++;
      if (req_ready !== 4'(1 << (i % 4))) begin
        mismatched++; $display("[TB] FAIL arith_ready[%0d]: got %b expected %b", i, req_ready, 4'(1 << (i % 4)));
      end
      @(posedge clk); #1;
      compared++;
      if (resp_valid !== 1'b1 || resp_result !== exps[i] || resp_id !== ID_W'(i % 4)) begin
        mismatched++;
        $display("[TB] FAIL arith_resp[%0d]: got v=%b r=%h id=%0d expected 1/%h/%0d",
                 i, resp_valid, resp_result, resp_id, exps[i], i % 4);
      end
`ifdef ALU_SHIFT_ILLEGAL_FLAG_EN
      compared++;
      if (resp_illegal !== (i == 9)) begin
        mismatched++; $display("[TB] FAIL arith_illegal[%0d]: got %b expected %b", i, resp_illegal, (i == 9));
      end
`endif
    end
    req_valid = '0;
    @(posedge clk); #1;
    compared++;
    if (resp_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL arith_drain: got %b expected 0", resp_valid);
    end
  endtask

  task automatic test_fairness();
    int expIdx;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 4'b0110, 16'h0001, 16'(i));
    for (int c = 0; c < 5; c++) begin
      expIdx = c % 4;
      #1;
      compared++;
      if (req_ready !== 4'(1 << expIdx)) begin
        mismatched++; $display("[TB] FAIL fair_ready[%0d]: got %b expected %b", c, req_ready, 4'(1 << expIdx));
      end
      @(posedge clk); #1;
      compared++;
      if (resp_valid !== 1'b1 || resp_id !== ID_W'(expIdx) || resp_result !== 16'(1 << expIdx)) begin
        mismatched++;
        $display("[TB] FAIL fair_resp[%0d]: got v=%b id=%0d r=%h expected 1/%0d/%h",
                 c, resp_valid, resp_id, resp_result, expIdx, 16'(1 << expIdx));
      end
    end
  endtask

  task automatic test_back_to_back();
    resp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      compared++;
      if (req_ready !== 4'b0000) begin
        mismatched++; $display("[TB] FAIL bp_ready[%0d]: got %b expected 0000", c, req_ready);
      end
      @(posedge clk); #1;
      compared++;
      if (resp_valid !== 1'b1 || resp_result !== 16'h0001 || resp_id !== 2'd0) begin
        mismatched++;
        $display("[TB] FAIL bp_hold[%0d]: got v=%b r=%h id=%0d expected 1/0001/0", c, resp_valid, resp_result, resp_id);
      end
    end
    resp_ready = 1'b1;
    #1;
    compared++;
    if (req_ready !== 4'b0010) begin
      mismatched++; $display("[TB] FAIL bp_refill_ready: got %b expected 0010", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    compared++;
    if (resp_valid !== 1'b1 || resp_result !== 16'h0002 || resp_id !== 2'd1) begin
      mismatched++;
      $display("[TB] FAIL bp_refill: got v=%b r=%h id=%0d expected 1/0002/1", resp_valid, resp_result, resp_id);
    end
    @(posedge clk); #1;
    compared++;
    if (resp_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL bp_drain: got %b expected 0", resp_valid);
    end
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0;
    req_valid  = '0;
    set_req(2, 4'b0110, 16'h0001, 16'd2);
    @(posedge clk); #1;
    compared++;
    if (resp_valid !== 1'b1 || resp_result !== 16'h0004 || resp_id !== 2'd2) begin
      mismatched++;
      $display("[TB] FAIL mid_full: got v=%b r=%h id=%0d expected 1/0004/2", resp_valid, resp_result, resp_id);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 4'b0110, 16'h0003, 16'(i));
    #1;
    compared++;
    if (req_ready !== 4'b0000) begin
      mismatched++; $display("[TB] FAIL mid_ready: got %b expected 0000", req_ready);
    end
    @(posedge clk); #1;
    compared++;
    if (resp_valid !== 1'b0 || resp_result !== 16'h0000 || resp_id !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset: got v=%b r=%h id=%0d expected 0/0000/0", resp_valid, resp_result, resp_id);
    end
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    #1;
    compared++;
    if (req_ready !== 4'b0001) begin
      mismatched++; $display("[TB] FAIL mid_ptr: got %b expected 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    compared++;
    if (resp_valid !== 1'b1 || resp_result !== 16'h0003 || resp_id !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL mid_after: got v=%b r=%h id=%0d expected 1/0003/0", resp_valid, resp_result, resp_id);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    resp_ready = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_opcode = '0;
    test_reset();
    test_single();
    test_arith();
    test_fairness();
    test_back_to_back();
    test_reset_mid();
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_shift_arbiter.md
Name: alu_shift_arbiter

Overview:
- Shares one 16-bit shift/rotate datapath between NUM_REQ independent requesters, each using a valid/ready handshake.
- Round-robin arbitration; the winner's operands go to the combinational shift unit, and the result is captured in a single-entry response register tagged with the requester ID.
- Sits between issue logic and writeback wherever several clients need the shifter.

Parameters:
- NUM_REQ, 4, number of requesters; range 2..16.
- DATA_W, 16, operand and result width; fixed at 16 for the shift unit.
- ID_W, $clog2(NUM_REQ), width of the response tag.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_a  in  NUM_REQ*DATA_W  operand A per requester; slice i = requester i
- req_b  in  NUM_REQ*DATA_W  shift amount per requester
- req_opcode  in  NUM_REQ*4  opcode per requester
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- resp_result  out  DATA_W  shift/rotate result
- resp_id  out  ID_W  index of the originating requester

Behaviour:
- Opcodes:
  - 4'b0110 SLL
  - 4'b0111 SAR
  - 4'b1000 ROTL
  - 4'b1001 ROTR
  - any other value is illegal.
- Arithmetic:
  - SLL: A<<B; B>=16 gives 0.
  - SAR: arithmetic right shift; B>=16 gives 16 copies of A[15].
  - ROTL/ROTR: amount = B[3:0]; amount 0 returns A unchanged.
  - Illegal opcode: result 16'h0000.
- Response register states:
  - EMPTY: resp_valid=0.
  - FULL: resp_valid=1; resp_result and resp_id are held stable until the handshake.
- can_accept = EMPTY, or (FULL and resp_ready).
- Grant:
  - When can_accept and any req_valid is set, grant the first asserted requester at or after rr_ptr (searching upward with wrap).
  - req_ready[g]=1 only for the granted requester g. All req_ready are 0 when can_accept=0.
  - req_ready depends combinationally on req_valid, rr_ptr, state and resp_ready.
  - req_ready has no combinational path from the request data.
- On accept:
  - Register the result and g in the same cycle; state becomes FULL next cycle.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Latency: accept at edge N gives resp_valid=1 after edge N, so the response is visible in cycle N+1.
- Drain and refill in the same cycle (FULL, resp_ready=1, new grant): the register loads the new result; state stays FULL. This gives back-to-back throughput of 1 per cycle.
- Drain without refill: state goes FULL -> EMPTY.
- rr_ptr is unchanged in cycles with no grant.
- A requester holding req_valid while not granted keeps its request pending; it is never dropped.
- Reset, including mid-operation: state=EMPTY, resp_valid=0, resp_result=0, resp_id=0, rr_ptr=0, req_ready=0. A pending response is discarded.
- NUM_REQ not a power of 2: the pointer wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro: ALU_SHIFT_ILLEGAL_FLAG_EN.
- Defined:
  - Adds output port resp_illegal (1 bit), registered with the response.
  - resp_illegal=1 when the captured opcode was illegal; reset value 0.
- Undefined: the port is absent; illegal opcodes silently produce 0.

Decomposition:
- Package alu_shift_pkg contains:
  - typedef enum logic [3:0] shift_op_e (SLL, SAR, ROTL, ROTR)
  - localparam DATA_W=16
  - function is_legal_op(shift_op_e)
- Sub-module alu_shift_unit: purely combinational datapath (A, B, opcode -> result), implementing the arithmetic rules above. It is instantiated once in alu_shift_arbiter.
- Arbitration and the response register live in the top module.

Test Plan:
- Single request: req0 SLL, A=16'h0001, B=4, resp_ready=1 -> one cycle later resp_valid=1, result=16'h0010, id=0.
- SAR sign fill and saturation: A=16'h8000 with B=3 -> 16'hF000; A=16'h8000 with B=20 -> 16'hFFFF.
- Rotate: ROTL A=16'h8001, B=1 -> 16'h0003; ROTR A=16'h8001, B=17 (amount 1) -> 16'hC000.
- Fairness: all 4 requesters hold valid with resp_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles; one response per cycle with matching ids.
- Backpressure: resp_ready=0 with response held -> req_ready all 0 and resp_result stable for 5 cycles. Raising resp_ready drains and refills in the same cycle.
- Reset mid-stream: assert rst_n=0 while FULL -> next cycle resp_valid=0 and rr_ptr=0. Illegal opcode 4'b1111 -> result 0, and resp_illegal=1 when ALU_SHIFT_ILLEGAL_FLAG_EN is defined.
